// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings, ALUOp classes and instruction opcode constants
package alu_pkg;
  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    XOR    = 3'b110
  } alu_ctl_t;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_CB    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: WIDTH-bit D register with asynchronous active-low clear
module pipe_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ALU-control decode, 64-bit ALU with flags, EX/MEM result register and flag hold
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] result_q,
  output logic [3:0]       flags_q
);
  alu_ctl_t ctl, rtype_ctl, imm_ctl;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0] sum;
  logic arith, n, v, c;
  always_comb begin
    rtype_ctl = (opcode == OP_ADD || opcode == OP_ADDS) ? ADD :
                (opcode == OP_SUB || opcode == OP_SUBS) ? SUB :
                opcode == OP_AND ? AND :
                opcode == OP_ORR ? OR :
                opcode == OP_EOR ? XOR : PASS_B;
    imm_ctl = opcode[10:1] == OP_ADDI ? ADD : opcode[10:1] == OP_SUBI ? SUB : ADD;
    ctl = alu_op == ALUOP_MEM ? ADD :
          alu_op == ALUOP_CB ? PASS_B :
          alu_op == ALUOP_RTYPE ? rtype_ctl : imm_ctl;
  end
  assign operation = ctl;
  // one adder serves add and subtract; subtract feeds ~B with carry-in 1
  always_comb begin
    arith = ctl == ADD || ctl == SUB;
    bx = ctl == SUB ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ctl == SUB};
    result = arith ? sum[WIDTH-1:0] :
             ctl == AND ? a & b :
             ctl == OR ? a | b :
             ctl == XOR ? a ^ b : b;
    c = arith & sum[WIDTH];
    v = arith & (a[WIDTH-1] == bx[WIDTH-1]) & (result[WIDTH-1] != a[WIDTH-1]);
    n = result[WIDTH-1];
  end
  assign zero = ~|result;
  pipe_reg #(.WIDTH(WIDTH)) u_result_reg (
    .clk(clk),
    .reset(reset),
    .d(result),
    .q(result_q)
  );
  // only compares (subtract) update the held flags for later conditional branches
  always_ff @(posedge clk or negedge reset)
    if (!reset) flags_q <= '0;
    else if (ctl == SUB) flags_q <= {n, zero, v, c};
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors with a queue-based scoreboard for alu_exec_stage
module tb_alu_exec_stage;
  logic clk = 0, reset = 0;
  logic [1:0] alu_op = 0;
  logic [10:0] opcode = 0;
  logic [63:0] a = 0, b = 0;
  logic [2:0] operation;
  logic [63:0] result, result_q;
  logic zero;
  logic [3:0] flags_q;
  int total = 0, passed = 0;
  typedef struct {
    string nm;
    logic [2:0] op;
    logic [63:0] res;
    logic z;
    logic [3:0] fq;
  } exp_t;
  exp_t q[$];
  exp_t pend;
  bit pend_v = 0;

  alu_exec_stage #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .opcode(opcode), .a(a), .b(b),
    .operation(operation), .result(result), .zero(zero),
    .result_q(result_q), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic vec(input string nm, input logic [1:0] ao, input logic [10:0] oc,
                     input logic [63:0] va, input logic [63:0] vb, input logic [2:0] eop,
                     input logic [63:0] eres, input logic ez, input logic [3:0] efq);
    exp_t e;
    @(posedge clk);
    #1;
    alu_op = ao; opcode = oc; a = va; b = vb;
    e.nm = nm; e.op = eop; e.res = eres; e.z = ez; e.fq = efq;
    q.push_back(e);
  endtask

  // monitor: registered outputs at this negedge reflect the previously popped vector
  initial forever begin
    @(negedge clk);
    if (pend_v) begin
      chk({pend.nm, " result_q"}, result_q, pend.res);
      chk({pend.nm, " flags_q"}, 64'(flags_q), 64'(pend.fq));
      pend_v = 0;
    end
    if (q.size() > 0) begin
      pend = q.pop_front();
      pend_v = 1;
      chk({pend.nm, " operation"}, 64'(operation), 64'(pend.op));
      chk({pend.nm, " result"}, result, pend.res);
      chk({pend.nm, " zero"}, 64'(zero), 64'(pend.z));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset result_q", result_q, 64'h0);
    chk("reset flags_q", 64'(flags_q), 64'h0);
    @(negedge clk);
    reset = 1;
    vec("add_mem", 2'b00, 11'd0, 64'h10, 64'h8, 3'b010, 64'h18, 0, 4'b0000);
    vec("subs_eq", 2'b10, 11'b11101011000, 64'd5, 64'd5, 3'b011, 64'h0, 1, 4'b0101);
    vec("sub_ovf", 2'b10, 11'b11001011000, 64'h8000000000000000, 64'd1, 3'b011,
        64'h7FFFFFFFFFFFFFFF, 0, 4'b0011);
    vec("and", 2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00, 3'b100, 64'hF000, 0, 4'b0011);
    vec("orr", 2'b10, 11'b10101010000, 64'hF0F0, 64'hFF00, 3'b101, 64'hFFF0, 0, 4'b0011);
    vec("eor", 2'b10, 11'b11001010000, 64'hF0F0, 64'hFF00, 3'b110, 64'h0FF0, 0, 4'b0011);
    vec("unknown", 2'b10, 11'b11111111111, 64'hF0F0, 64'hFF00, 3'b000, 64'hFF00, 0, 4'b0011);
    vec("adds_wrap", 2'b10, 11'b10101011000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 3'b010, 64'h0, 1, 4'b0011);
    vec("cbz", 2'b01, 11'd0, 64'h1234, 64'h0, 3'b000, 64'h0, 1, 4'b0011);
    vec("addi", 2'b11, 11'b10010001000, 64'd100, 64'd23, 3'b010, 64'd123, 0, 4'b0011);
    vec("subi_neg", 2'b11, 11'b11010001001, 64'd3, 64'd5, 3'b011, 64'hFFFFFFFFFFFFFFFE, 0, 4'b1000);
    vec("imm_other", 2'b11, 11'd0, 64'd7, 64'd9, 3'b010, 64'd16, 0, 4'b1000);
    vec("subs_pre", 2'b10, 11'b11101011000, 64'd5, 64'd5, 3'b011, 64'h0, 1, 4'b0101);
    vec("add_pre", 2'b00, 11'd0, 64'h10, 64'h8, 3'b010, 64'h18, 0, 4'b0101);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 0;
    #1;
    chk("async clear result_q", result_q, 64'h0);
    chk("async clear flags_q", 64'(flags_q), 64'h0);
    @(posedge clk);
    #1;
    chk("held result_q", result_q, 64'h0);
    chk("held flags_q", 64'(flags_q), 64'h0);
    chk("comb during reset", result, 64'h18);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("post-reset result_q", result_q, 64'h18);
    chk("post-reset flags_q", 64'(flags_q), 64'h0);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath slice of the pipelined 64-bit ARM CPU.
- Combines three functions:
  - ALU-control decode: ALUOp class plus 11-bit opcode field, producing a 3-bit operation.
  - 64-bit ALU with N/Z/V/C flags.
  - Execute/Memory pipeline register for the ALU result.
- Also holds the condition flags for later conditional branches.
- Sits between the register-fetch pipeline register and data memory.

Parameters:
- WIDTH, 64, datapath width of operands, result and pipeline register.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- alu_op  in  2  ALU operation class from main control
- opcode  in  11  instruction bits [31:21]
- a  in  WIDTH  operand A (Rn)
- b  in  WIDTH  operand B (Rm, immediate or address offset, already selected)
- operation  out  3  decoded ALU control (combinational)
- result  out  WIDTH  combinational ALU result
- zero  out  1  combinational zero flag, used for CBZ
- result_q  out  WIDTH  registered result (EX/MEM)
- flags_q  out  4  held flags {N,Z,V,C}

Behaviour:
- Operation encoding:
  - 000 pass B
  - 010 add
  - 011 subtract (A-B)
  - 100 AND
  - 101 OR
  - 110 XOR
  - 001 and 111 behave as pass B
- Decode by alu_op:
  - 00: add (loads, stores, address calculation).
  - 01: pass B (CBZ/CBNZ test of register).
  - 10 (R-type), by opcode:
    - ADD 10001011000, ADDS 10101011000: add
    - SUB 11001011000, SUBS 11101011000: sub
    - AND 10001010000: AND
    - ORR 10101010000: OR
    - EOR 11001010000: XOR
    - any other: pass B
  - 11 (immediate), by opcode[10:1]:
    - ADDI 1001000100: add
    - SUBI 1101000100: sub
    - any other: add
- Arithmetic:
  - Add: A+B, modulo 2^WIDTH.
  - Sub: A + ~B + 1.
  - C: carry out of bit WIDTH-1 of the internal adder. For subtract, C=1 means no borrow.
  - V: operand signs agree (B inverted for sub) and result sign differs.
  - For logic ops and pass B: C=0 and V=0.
  - N = result[WIDTH-1]; Z = (result==0).
- Result pipeline register:
  - result_q <= result on every rising clk.
  - No enable, no stall.
  - Latency 1 cycle.
- Flag hold:
  - flags_q <= {N,Z,V,C} on rising clk only when operation==011 (subtract).
  - Otherwise flags_q holds its value.
  - Add and logic ops never modify flags_q.
- Reset:
  - reset low asynchronously clears result_q=0 and flags_q=0, immediately and independent of clk.
  - Registers remain cleared while reset is low.
  - The first capture is the first rising clk after reset goes high.
- Combinational outputs (operation, result, zero) do not depend on reset.
- No X propagation on unknown opcode: the defaults above apply.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_ctl_t (3-bit enum PASS_B, ADD, SUB, AND, OR, XOR).
  - ALUOp class constants (MEM, CB, RTYPE, IMM).
  - 11-bit opcode constants.
- One sub-module: pipe_reg, a WIDTH-parameterised async-active-low-reset D register, instantiated for result_q.
- The flag hold stays inline.
- Decode and ALU are always_comb blocks in the top module.

Test Plan:
- Add via alu_op=00, a=0x10, b=0x8:
  - Response: operation=010, result=0x18.
  - Next clk: result_q=0x18.
  - flags_q unchanged.
- SUBS via alu_op=10, opcode=11101011000, a=5, b=5:
  - Response: result=0, zero=1.
  - Next clk: flags_q=0101 (N=0, Z=1, V=0, C=1).
- Signed overflow, sub, a=0x8000000000000000, b=1:
  - Response: result=0x7FFFFFFFFFFFFFFF.
  - Next clk: flags_q=0011 (V=1, C=1).
- Logic ops (alu_op=10), a=0xF0F0, b=0xFF00:
  - AND: 0xF000.
  - ORR: 0xFFF0.
  - EOR: 0x0FF0.
  - Unknown opcode 11111111111: result=b=0xFF00.
  - flags_q unchanged throughout.
- CBZ path, alu_op=01, b=0: operation=000, zero=1, result_q=0 after clk.
- Reset mid-operation:
  - With result_q=0x18 and flags_q=0101, drive reset low between clock edges.
  - Response: result_q=0 and flags_q=0 immediately; they stay 0 while reset is low.
  - After release, the next clk captures the current result.
